// File: rtl/state_sequencer_if.sv
// Handshake bundle between the acquisition sequencer and the state switch.
// The sequencer selects a sub-state and ticks it; the switch acknowledges and returns the interval.
interface state_sequencer_if #(
  parameter int DATA_W = 22
);
  logic [4:0]        start;
  logic              time_up;
  logic              state_start;
  logic              state_over_n;
  logic [DATA_W-1:0] datain;

  modport master (
    output start,
    output time_up,
    input  state_start,
    input  state_over_n,
    input  datain
  );

  modport slave (
    input  start,
    input  time_up,
    output state_start,
    output state_over_n,
    output datain
  );
endinterface

// File: rtl/state_sequencer.sv
// Walks the enabled acquisition sub-states (scale, scan, noise, pluse, st1ms) in order,
// selecting each on the state switch and ticking it at the interval the switch returns.
module state_sequencer #(
  parameter int DATA_W  = 22,
  parameter int MIN_IVL = 1
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   go,
  input  logic [4:0]             seq_mask,
  input  logic                   loop,
  input  logic                   abort,
  state_sequencer_if.master      sw,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             cur_idx
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEL  = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [2:0] IDX_ST1MS = 3'd4;
  localparam logic [2:0] IDX_NONE  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [4:0]        mask_q, mask_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [4:0]        start_q, start_d;
  logic              time_up_q, time_up_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        cur_idx_q, cur_idx_d;
  logic [DATA_W-1:0] ivl;
  logic [3:0]        nxt;

  function automatic logic [2:0] lowest_bit(input logic [4:0] m);
    lowest_bit = IDX_NONE;
    for (int i = 4; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // {found, index} of the lowest enabled bit strictly above cur
  function automatic logic [3:0] next_above(input logic [4:0] m, input logic [2:0] cur);
    next_above = 4'b0000;
    for (int i = 4; i >= 0; i--) begin
      if (m[i] && (3'(i) > cur)) next_above = {1'b1, 3'(i)};
    end
  endfunction

  function automatic logic [DATA_W-1:0] clamp_ivl(input logic [DATA_W-1:0] d);
    if (d < DATA_W'(MIN_IVL)) clamp_ivl = DATA_W'(MIN_IVL);
    else                      clamp_ivl = d;
  endfunction

  function automatic logic [4:0] onehot(input logic [2:0] idx);
    onehot = 5'd1 << idx;
  endfunction

  assign ivl = clamp_ivl(sw.datain);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    start_d   = start_q;
    time_up_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cur_idx_d = cur_idx_q;
    nxt       = next_above(mask_q, idx_q);

    case (state_q)
      S_IDLE: begin
        if (go && !abort && (seq_mask != 5'd0)) begin
          mask_d  = seq_mask;
          idx_d   = lowest_bit(seq_mask);
          busy_d  = 1'b1;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        start_d   = onehot(idx_q);
        cur_idx_d = idx_q;
        state_d   = S_ACK;
      end
      S_ACK: begin
        if (sw.state_start) begin
          cnt_d   = ivl;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // st1ms leaves once its single tick has been presented with start still held
        if (idx_q == IDX_ST1MS) begin
          if (time_up_q) begin
            start_d = 5'd0;
            state_d = S_GAP;
          end else if (cnt_q <= DATA_W'(1)) begin
            time_up_d = 1'b1;
            cnt_d     = ivl;
          end else begin
            cnt_d = cnt_q - DATA_W'(1);
          end
        end else if (!sw.state_over_n) begin
          start_d = 5'd0;
          state_d = S_GAP;
        end else if (cnt_q <= DATA_W'(1)) begin
          time_up_d = 1'b1;
          cnt_d     = ivl;
        end else begin
          cnt_d = cnt_q - DATA_W'(1);
        end
      end
      S_GAP: begin
        if (nxt[3]) begin
          idx_d   = nxt[2:0];
          state_d = S_SEL;
        end else if (loop) begin
          mask_d = seq_mask;
          if (seq_mask != 5'd0) begin
            idx_d   = lowest_bit(seq_mask);
            state_d = S_SEL;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        cur_idx_d = IDX_NONE;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      start_d   = 5'd0;
      time_up_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      cur_idx_d = IDX_NONE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mask_q    <= 5'd0;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      start_q   <= 5'd0;
      time_up_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cur_idx_q <= IDX_NONE;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      time_up_q <= time_up_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cur_idx_q <= cur_idx_d;
    end
  end

  assign sw.start   = start_q;
  assign sw.time_up = time_up_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cur_idx    = cur_idx_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Bench for state_sequencer: acts as the state switch and sub-states, predicts
// start/tick/gap/done events from interval arithmetic and matches them in order.
module tb_state_sequencer;
  localparam int DATA_W = 22;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       go;
  logic [4:0] seq_mask;
  logic       loop;
  logic       abort;
  logic       busy;
  logic       done;
  logic [2:0] cur_idx;

  state_sequencer_if #(.DATA_W(DATA_W)) sw ();

  state_sequencer #(.DATA_W(DATA_W), .MIN_IVL(1)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .go       (go),
    .seq_mask (seq_mask),
    .loop     (loop),
    .abort    (abort),
    .sw       (sw),
    .busy     (busy),
    .done     (done),
    .cur_idx  (cur_idx)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum int {EV_START = 0, EV_TICK = 1, EV_GAP = 2, EV_DONE = 3} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       cyc;
  } ev_t;

  typedef struct {
    logic [4:0] mask;
    int         ivl;
    int         k;           // ticks before completion for indices 0-3
    int         passes;
    bit         loop_zero;   // loop held, seq_mask cleared after go
    int         exp_starts;
    int         exp_dones;
  } vec_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  ss_next;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return 7;
  endfunction

  // Switch model: state_start is start registered once, valid only for one-hot selects
  task automatic step();
    ss_next = ($countones(sw.start) == 1) && !rst;
    @(posedge clk_sys);
    #1;
    sw.state_start = ss_next && !rst;
  endtask

  task automatic got_ev(input ev_kind_t k, input int idx, input int cyc);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d idx %0d at cycle %0d, expected none", int'(k), idx, cyc);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("ev_kind@%0d", cyc), int'(k), int'(e.kind));
      chk($sformatf("ev_idx@%0d", cyc), idx, e.idx);
      chk($sformatf("ev_cycle_kind%0d", int'(e.kind)), cyc, e.cyc);
    end
  endtask

  task automatic run_vec(input vec_t v, input int vn);
    int n, s, t, total, cyc, ticks, comps, cur, obs_starts, obs_dones, done_cyc;
    bit done_seen;
    logic [4:0] prev_start, st;

    exp_q.delete();
    n     = (v.ivl < 1) ? 1 : v.ivl;
    s     = 2;
    t     = 0;
    total = 0;
    for (int p = 0; p < v.passes; p++) begin
      for (int i = 0; i < 5; i++) begin
        if (v.mask[i]) begin
          int kk;
          kk = (i == 4) ? 1 : v.k;
          exp_q.push_back('{EV_START, i, s});
          for (int j = 1; j <= kk; j++) exp_q.push_back('{EV_TICK, i, s + 2 + j * n});
          t = s + 2 + kk * n;
          exp_q.push_back('{EV_GAP, i, t + 1});
          s = t + 3;
          total++;
        end
      end
    end
    exp_q.push_back('{EV_DONE, 7, s});

    seq_mask        = v.mask;
    loop            = (v.passes > 1) || v.loop_zero;
    sw.datain       = DATA_W'(v.ivl);
    sw.state_over_n = 1'b1;
    go              = 1'b1;
    cyc = 0; ticks = 0; comps = 0; cur = 7; obs_starts = 0; obs_dones = 0;
    done_seen = 1'b0; done_cyc = 0;
    prev_start = sw.start;

    while (cyc < 2000 && !(done_seen && cyc >= done_cyc + 3)) begin
      step();
      cyc++;
      sw.state_over_n = 1'b1;
      go = (cyc == 5);
      if (cyc == 1 && v.loop_zero) seq_mask = 5'd0;
      if (cyc == 5) seq_mask = 5'b11111;
      if (cyc == 6) seq_mask = v.loop_zero ? 5'd0 : v.mask;
      if (cyc == 1) chk($sformatf("v%0d_busy_after_go", vn), int'(busy), 1);

      st = sw.start;
      if (st !== prev_start) begin
        if (st != 5'd0) begin
          cur = oh2idx(st);
          chk($sformatf("v%0d_start_onehot", vn), $countones(st), 1);
          chk($sformatf("v%0d_cur_idx_at_start", vn), int'(cur_idx), cur);
          got_ev(EV_START, cur, cyc);
          obs_starts++;
          ticks = 0;
        end else begin
          got_ev(EV_GAP, int'(cur_idx), cyc);
        end
      end
      prev_start = st;

      if (sw.time_up === 1'b1) begin
        got_ev(EV_TICK, int'(cur_idx), cyc);
        ticks++;
        if (cur < 4 && ticks == v.k) begin
          sw.state_over_n = 1'b0;
          comps++;
        end else if (cur == 4) begin
          comps++;
        end
        if (comps == total && !v.loop_zero) loop = 1'b0;
      end

      if (done === 1'b1) begin
        got_ev(EV_DONE, int'(cur_idx), cyc);
        chk($sformatf("v%0d_busy_with_done", vn), int'(busy), 0);
        obs_dones++;
        if (!done_seen) done_cyc = cyc;
        done_seen = 1'b1;
      end
    end

    go = 1'b0;
    loop = 1'b0;
    chk($sformatf("v%0d_done_seen", vn), int'(done_seen), 1);
    chk($sformatf("v%0d_events_left", vn), exp_q.size(), 0);
    chk($sformatf("v%0d_starts", vn), obs_starts, v.exp_starts);
    chk($sformatf("v%0d_dones", vn), obs_dones, v.exp_dones);
    chk($sformatf("v%0d_idle_cur_idx", vn), int'(cur_idx), 7);
    chk($sformatf("v%0d_idle_busy", vn), int'(busy), 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   bad_busy, bad_done, bad_tick;

    vecs[0] = '{5'b00001, 4, 3, 1, 1'b0, 1, 1};
    vecs[1] = '{5'b10110, 3, 2, 1, 1'b0, 3, 1};
    vecs[2] = '{5'b00001, 0, 3, 1, 1'b0, 1, 1};
    vecs[3] = '{5'b11111, 2, 1, 1, 1'b0, 5, 1};
    vecs[4] = '{5'b01000, 2, 1, 1, 1'b1, 1, 1};
    vecs[5] = '{5'b00011, 1, 1, 2, 1'b0, 4, 1};
    vecs[6] = '{5'b10000, 1, 1, 1, 1'b0, 1, 1};

    rst = 1'b1; go = 1'b0; seq_mask = 5'd0; loop = 1'b0; abort = 1'b0;
    sw.state_start = 1'b0; sw.state_over_n = 1'b1; sw.datain = '0;
    repeat (3) step();
    chk("rst_start", int'(sw.start), 0);
    chk("rst_time_up", int'(sw.time_up), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cur_idx", int'(cur_idx), 7);
    rst = 1'b0;
    step();

    // go with an empty mask is ignored
    go = 1'b1; seq_mask = 5'd0;
    step();
    go = 1'b0;
    bad_busy = 0; bad_done = 0;
    repeat (4) begin
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
      step();
    end
    chk("zero_mask_busy_cycles", bad_busy, 0);
    chk("zero_mask_done_cycles", bad_done, 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      repeat (2) step();
    end

    // abort mid-RUN together with go
    seq_mask = 5'b00001; sw.datain = DATA_W'(4); loop = 1'b0; go = 1'b1;
    step();
    go = 1'b0;
    repeat (5) step();
    abort = 1'b1; go = 1'b1;
    step();
    abort = 1'b0; go = 1'b0;
    chk("abort_start", int'(sw.start), 0);
    chk("abort_time_up", int'(sw.time_up), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_cur_idx", int'(cur_idx), 7);
    bad_busy = 0; bad_done = 0; bad_tick = 0;
    repeat (12) begin
      step();
      if (busy !== 1'b0) bad_busy++;
      if (done !== 1'b0) bad_done++;
      if (sw.time_up !== 1'b0) bad_tick++;
    end
    chk("abort_busy_cycles", bad_busy, 0);
    chk("abort_done_cycles", bad_done, 0);
    chk("abort_tick_cycles", bad_tick, 0);
    run_vec(vecs[0], 10);
    repeat (2) step();

    // reset during ACK, with go in the same cycle
    seq_mask = 5'b00010; sw.datain = DATA_W'(3); go = 1'b1;
    step();
    go = 1'b0;
    step();
    chk("pre_rst_start", int'(sw.start), 2);
    rst = 1'b1; go = 1'b1;
    step();
    rst = 1'b0; go = 1'b0;
    chk("ack_rst_start", int'(sw.start), 0);
    chk("ack_rst_time_up", int'(sw.time_up), 0);
    chk("ack_rst_busy", int'(busy), 0);
    chk("ack_rst_done", int'(done), 0);
    chk("ack_rst_cur_idx", int'(cur_idx), 7);
    step();
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_start", int'(sw.start), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
